serial_adder: RTL

Parametrised bit-serial adder/incrementer. It replaces the fixed 4-bit half-adder ripple chain with a single full-adder slice that is iterated over WIDTH clock cycles, using a start/busy/done handshake. Two modes: two-operand add (A+B) and increment (A+1). The full-width result includes carry-out. It sits beside datapath blocks that need an occasional wide add or increment and can wait for it instead of paying for a full ripple chain.

---
 rtl/serial_adder.sv | 135 +++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder
// Purpose  : Bit-serial adder / incrementer. One full-adder slice is iterated
//            over WIDTH clock cycles behind a start/busy/done handshake.
//            mode=0 computes A+B, mode=1 computes A+1. The result is WIDTH+1
//            bits wide, with the carry-out in the MSB.
// Revision : 1.0 - initial release
// ============================================================================
module serial_adder #(
  parameter int WIDTH = 8  // operand width, legal range 2..32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_mode,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH:0]   o_sum
);

  // Bit counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice.
  localparam int            CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] c_ONE  = CW'(1);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_RUN  = 2'd1;
  localparam logic [1:0] c_ST_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;

  logic [WIDTH-1:0] r_a;        // operand A, consumed LSB first
  logic [WIDTH-1:0] r_b;        // operand B (zero in increment mode)
  logic             r_carry;    // running carry between bit steps
  logic [CW-1:0]    r_cnt;      // index of the bit being processed
  logic [WIDTH-2:0] r_res;      // sum bits 0..WIDTH-2, filled from the top
  logic [WIDTH:0]   r_sum;      // published result, updated on completion only

  logic             w_accept;
  logic             w_run;
  logic             w_last;
  logic             w_s;
  logic             w_cout;
  logic [WIDTH-2:0] w_res_shift;

  // A request is honoured only when no operation is in flight.
  assign w_accept = i_start && ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE));
  assign w_run    = (r_state == c_ST_RUN);
  assign w_last   = w_run && (r_cnt == c_LAST);

  // The single full-adder slice.
  assign w_s    = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_cout = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);

  // The partial-result register is one bit wide when WIDTH=2, so there is
  // nothing to shift down in that case.
  if (WIDTH == 2) begin : g_res_single
    assign w_res_shift = w_s;
  end else begin : g_res_multi
    assign w_res_shift = {w_s, r_res[WIDTH-2:1]};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: DONE lasts one cycle unless a new request chains on.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_IDLE: w_next_state = w_accept ? c_ST_RUN : c_ST_IDLE;
      c_ST_RUN:  w_next_state = (r_cnt == c_LAST) ? c_ST_DONE : c_ST_RUN;
      c_ST_DONE: w_next_state = w_accept ? c_ST_RUN : c_ST_IDLE;
      default:   w_next_state = c_ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state; busy and done are mutually exclusive.
  always_comb begin
    o_busy = 1'b0;
    o_done = 1'b0;
    case (r_state)
      c_ST_RUN:  o_busy = 1'b1;
      c_ST_DONE: o_done = 1'b1;
      default: begin
        o_busy = 1'b0;
        o_done = 1'b0;
      end
    endcase
  end

  // Datapath: capture operands on accept, then one bit per cycle while running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_res   <= '0;
    end else if (w_accept) begin
      r_a     <= i_a;
      r_b     <= i_mode ? '0 : i_b;
      r_carry <= i_mode;
      r_cnt   <= '0;
    end else if (w_run) begin
      r_a     <= {1'b0, r_a[WIDTH-1:1]};
      r_b     <= {1'b0, r_b[WIDTH-1:1]};
      r_carry <= w_cout;
      r_cnt   <= r_cnt + c_ONE;
      r_res   <= w_res_shift;
    end
  end

  // Result register: changes only on the completion edge and holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
    end else if (w_last) begin
      r_sum <= {w_cout, w_s, r_res};
    end
  end

  assign o_sum = r_sum;

endmodule
`default_nettype wire
